// File: rtl/avl_button_led_slave.sv
// avl_button_led_slave
//   Avalon-MM responder giving the Nios II a debounced user button and a
//   board LED register. The button path is a 2-FF synchroniser followed by
//   a counter debounce. Debounced presses set a sticky EDGE flag, which
//   drives a maskable level IRQ, and bump an 8-bit wrapping press counter.
//
//   Register map (word addresses):
//     0 DATA  RO  bit0 = pressed, bits[15:8] = press count (any write clears)
//     1 EDGE  W1C bit0 = press seen (a set in the same cycle beats the clear)
//     2 MASK  RW  bit0 = irq enable
//     3 LED   RW  bits[LED_WIDTH-1:0]
//
// Ports
//   CLK12M         system clock
//   RST_BTN        asynchronous active-low reset
//   avs_address    word address
//   avs_read       read strobe; avs_readdata is valid the following cycle
//   avs_write      write strobe; the write takes effect on the same edge
//   avs_writedata  write data
//   avs_readdata   registered read data, 0 in the cycle after a non-read
//   irq            EDGE[0] & MASK[0]
//   USER_BTN       raw asynchronous button pin
//   LED            LED drive, straight from the LED register
module avl_button_led_slave #(
  parameter int   DEBOUNCE_CYCLES = 120000,
  parameter int   LED_WIDTH       = 8,
  parameter logic BTN_PRESS_LEVEL = 1'b0
) (
  input  logic                 CLK12M,
  input  logic                 RST_BTN,
  input  logic [1:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 irq,
  input  logic                 USER_BTN,
  output logic [LED_WIDTH-1:0] LED
);

  localparam int             CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic           RELEASED = ~BTN_PRESS_LEVEL;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_EDGE = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_LED  = 2'd3;

  // ---------------------------------------------------------------------
  // Synchroniser + debounce
  // ---------------------------------------------------------------------
  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] dbc_q, dbc_d;
  logic          press_evt;

  // Sync flops come out of reset at the released level so a button held
  // through reset is seen as a fresh change and counted from zero.
  always_ff @(posedge CLK12M or negedge RST_BTN) begin
    if (!RST_BTN) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
    end else begin
      sync1_q <= USER_BTN;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    stable_d  = stable_q;
    dbc_d     = '0;
    press_evt = 1'b0;
    if (sync2_q != stable_q) begin
      if (dbc_q == CNT_MAX) begin
        stable_d  = sync2_q;
        press_evt = (sync2_q == BTN_PRESS_LEVEL);
      end else begin
        dbc_d = dbc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK12M or negedge RST_BTN) begin
    if (!RST_BTN) begin
      stable_q <= RELEASED;
      dbc_q    <= '0;
    end else begin
      stable_q <= stable_d;
      dbc_q    <= dbc_d;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic                 wr_data, wr_edge, wr_mask, wr_led;
  logic [7:0]           pcnt_q, pcnt_d;
  logic                 edge_q, edge_d;
  logic                 mask_q, mask_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 pressed;

  assign wr_data = avs_write && (avs_address == A_DATA);
  assign wr_edge = avs_write && (avs_address == A_EDGE);
  assign wr_mask = avs_write && (avs_address == A_MASK);
  assign wr_led  = avs_write && (avs_address == A_LED);
  assign pressed = (stable_q == BTN_PRESS_LEVEL);

  always_comb begin
    // A write to DATA clears the counter; a press landing on the same edge
    // is still counted, giving 1.
    pcnt_d = pcnt_q;
    if (wr_data)        pcnt_d = {7'd0, press_evt};
    else if (press_evt) pcnt_d = pcnt_q + 8'd1;

    // Set wins over write-one-to-clear so a press is never lost.
    edge_d = press_evt | (edge_q & ~(wr_edge & avs_writedata[0]));

    mask_d = wr_mask ? avs_writedata[0] : mask_q;
    led_d  = wr_led  ? avs_writedata[LED_WIDTH-1:0] : led_q;

    // Read mux sees current register values, so a simultaneous write is
    // returned as the pre-write value.
    rdata_d = '0;
    if (avs_read) begin
      unique case (avs_address)
        A_DATA:  rdata_d = {16'd0, pcnt_q, 7'd0, pressed};
        A_EDGE:  rdata_d = {31'd0, edge_q};
        A_MASK:  rdata_d = {31'd0, mask_q};
        default: rdata_d = 32'(led_q);
      endcase
    end
  end

  always_ff @(posedge CLK12M or negedge RST_BTN) begin
    if (!RST_BTN) begin
      pcnt_q  <= '0;
      edge_q  <= 1'b0;
      mask_q  <= 1'b0;
      led_q   <= '0;
      rdata_q <= '0;
    end else begin
      pcnt_q  <= pcnt_d;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      led_q   <= led_d;
      rdata_q <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = edge_q & mask_q;
  assign LED          = led_q;

  // Write-data bits above the widest register field are ignored.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

endmodule

// File: tb/tb_avl_button_led_slave.sv
// Directed bench for avl_button_led_slave with DEBOUNCE_CYCLES=8,
// LED_WIDTH=8, active-low button.
module tb_avl_button_led_slave;

  logic        CLK12M;
  logic        RST_BTN;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  logic        USER_BTN;
  logic [7:0]  LED;

  int n_chk  = 0;
  int n_pass = 0;

  avl_button_led_slave #(
    .DEBOUNCE_CYCLES(8),
    .LED_WIDTH      (8),
    .BTN_PRESS_LEVEL(1'b0)
  ) dut (
    .CLK12M       (CLK12M),
    .RST_BTN      (RST_BTN),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq),
    .USER_BTN     (USER_BTN),
    .LED          (LED)
  );

  initial CLK12M = 1'b0;
  always #5 CLK12M = ~CLK12M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLK12M);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  task automatic btn_press();
    USER_BTN = 1'b0;
    repeat (12) tick();
  endtask

  task automatic btn_release();
    USER_BTN = 1'b1;
    repeat (12) tick();
  endtask

  // Hold a DATA read running while the button goes down; readdata after
  // tick n reflects state after edge n-1, so pressed shows first at n=11
  // (stable updates on edge 10 = 2 sync + 8 debounce).
  task automatic press_latency(input string tag);
    USER_BTN    = 1'b0;
    avs_address = 2'd0;
    avs_read    = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      tick();
      chk(tag, {31'd0, avs_readdata[0]}, {31'd0, (n >= 11)});
    end
    avs_read = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    RST_BTN       = 1'b0;
    USER_BTN      = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;

    // 1. Reset state and empty readback
    repeat (3) tick();
    chk("rst_led",   {24'd0, LED}, 32'h0);
    chk("rst_irq",   {31'd0, irq}, 32'h0);
    chk("rst_rdata", avs_readdata, 32'h0);
    RST_BTN = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      chk("rst_read", rd, 32'h0);
    end

    // 2. Glitch shorter than the debounce window is ignored
    USER_BTN = 1'b0;
    repeat (5) tick();
    USER_BTN = 1'b1;
    repeat (12) tick();
    bus_read(2'd0, rd); chk("glitch_data", rd, 32'h0);
    bus_read(2'd1, rd); chk("glitch_edge", rd, 32'h0);
    press_latency("press_lat");
    bus_read(2'd0, rd); chk("press1_data", rd, 32'h0000_0101);
    bus_read(2'd1, rd); chk("press1_edge", rd, 32'h1);
    chk("masked_irq", {31'd0, irq}, 32'h0);
    tick();
    chk("rdata_idle", avs_readdata, 32'h0);

    // 3. Interrupt
    bus_write(2'd1, 32'h1);
    btn_release();
    bus_read(2'd0, rd); chk("rel_data", rd, 32'h0000_0100);
    bus_read(2'd1, rd); chk("rel_edge", rd, 32'h0);
    bus_write(2'd2, 32'h1);
    chk("irq_idle", {31'd0, irq}, 32'h0);
    USER_BTN = 1'b0;
    repeat (9) tick();
    chk("irq_before", {31'd0, irq}, 32'h0);
    tick();
    chk("irq_press", {31'd0, irq}, 32'h1);
    bus_write(2'd1, 32'h0);
    chk("irq_w0", {31'd0, irq}, 32'h1);
    bus_write(2'd1, 32'h1);
    chk("irq_w1c", {31'd0, irq}, 32'h0);
    // set/clear collision: clear lands on the press_evt edge
    btn_release();
    USER_BTN = 1'b0;
    repeat (9) tick();
    bus_write(2'd1, 32'h1);
    chk("edge_setwins_irq", {31'd0, irq}, 32'h1);
    bus_read(2'd1, rd); chk("edge_setwins", rd, 32'h1);
    bus_read(2'd0, rd); chk("press3_data", rd, 32'h0000_0301);
    bus_write(2'd2, 32'h0);
    chk("irq_mask0", {31'd0, irq}, 32'h0);
    bus_write(2'd2, 32'h1);
    chk("irq_unmask", {31'd0, irq}, 32'h1);

    // 4. Press counter wrap and write/press collision
    btn_release();
    bus_write(2'd0, 32'h0);
    bus_read(2'd0, rd); chk("cnt_clr", rd, 32'h0);
    for (int i = 0; i < 255; i++) begin
      btn_press();
      btn_release();
    end
    bus_read(2'd0, rd); chk("cnt_255", rd, 32'h0000_FF00);
    btn_press();
    btn_release();
    bus_read(2'd0, rd); chk("cnt_wrap", rd, 32'h0);
    USER_BTN = 1'b0;
    repeat (9) tick();
    bus_write(2'd0, 32'hDEAD_BEEF);
    tick();
    bus_read(2'd0, rd); chk("cnt_wr_press", rd, 32'h0000_0101);

    // 5. LED register
    bus_write(2'd3, 32'h0000_00A5);
    chk("led_a5", {24'd0, LED}, 32'hA5);
    bus_read(2'd3, rd); chk("led_rd", rd, 32'h0000_00A5);
    // simultaneous read and write returns the pre-write value
    avs_address   = 2'd3;
    avs_writedata = 32'h0000_003C;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    tick();
    avs_read  = 1'b0;
    avs_write = 1'b0;
    chk("rw_old", avs_readdata, 32'h0000_00A5);
    chk("rw_led", {24'd0, LED}, 32'h3C);
    bus_write(2'd3, 32'hFFFF_FF00);
    chk("led_0", {24'd0, LED}, 32'h0);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, rd); chk("mask_rd", rd, 32'h1);

    // 6. Reset mid-debounce
    btn_release();
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h1);
    chk("pre_rst_irq", {31'd0, irq}, 32'h1);
    chk("pre_rst_led", {24'd0, LED}, 32'hFF);
    USER_BTN = 1'b0;
    repeat (6) tick();
    bus_read(2'd0, rd); chk("pre_rst_rd", rd, 32'h0000_0100);
    RST_BTN = 1'b0;
    #1;
    chk("mid_rst_led",   {24'd0, LED}, 32'h0);
    chk("mid_rst_irq",   {31'd0, irq}, 32'h0);
    chk("mid_rst_rdata", avs_readdata, 32'h0);
    repeat (2) tick();
    RST_BTN = 1'b1;
    press_latency("post_rst_lat");
    bus_read(2'd1, rd); chk("post_rst_edge", rd, 32'h1);
    bus_read(2'd0, rd); chk("post_rst_data", rd, 32'h0000_0101);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
